// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Number of bits needed to hold values 0 .. v-1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational BPC-bit ripple adder; also exposes the carry into its MSB.
module fa_slice #(
   parameter int unsigned BPC = 1
) (
   input  logic [BPC-1:0] a,
   input  logic [BPC-1:0] b,
   input  logic           ci,
   output logic [BPC-1:0] s,
   output logic           co,
   output logic           cmsb
);

   logic c;

   always_comb begin
      c    = ci;
      cmsb = ci;
      s    = '0;
      for (int unsigned i = 0; i < BPC; i++) begin
         if (i == BPC - 1) begin
            cmsb = c;
         end
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder processing BPC bits per clock with valid/ready handshakes.
// Optional subtract port enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BPC   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned N  = WIDTH / BPC;
   localparam int unsigned CW = clog2(N + 1);

   generate
      if ((WIDTH % BPC) != 0 || WIDTH < 2 || BPC < 1) begin : g_param_check
         $error("serial_adder: WIDTH must be >= 2 and a multiple of BPC");
      end
   endgenerate

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sr, b_sr, sum_r, sum_nx, b_eff;
   logic [CW-1:0]    cnt;
   logic             carry, ovf_r, c_eff;
   logic [BPC-1:0]   s_slice;
   logic             co_slice, cmsb_slice;

   fa_slice #(.BPC(BPC)) u_fa (
      .a    (a_sr[BPC-1:0]),
      .b    (b_sr[BPC-1:0]),
      .ci   (carry),
      .s    (s_slice),
      .co   (co_slice),
      .cmsb (cmsb_slice)
   );

   // Result bits enter from the MSB side so the final slice lands on top.
   generate
      if (WIDTH == BPC) begin : g_sum_full
         assign sum_nx = s_slice;
      end else begin : g_sum_shift
         assign sum_nx = {s_slice, sum_r[WIDTH-1:BPC]};
      end
   endgenerate

   always_comb begin
      b_eff = b;
      c_eff = cin;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         b_eff = ~b;
         c_eff = 1'b1;
      end
`endif
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = CALC;
         end
         CALC: begin
            if (cnt == CW'(1)) state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         sum_r <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b_eff;
                  carry <= c_eff;
                  cnt   <= CW'(N);
               end
            end
            CALC: begin
               a_sr  <= a_sr >> BPC;
               b_sr  <= b_sr >> BPC;
               sum_r <= sum_nx;
               carry <= co_slice;
               ovf_r <= cmsb_slice ^ co_slice;
               cnt   <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign sum      = sum_r;
   assign cout     = carry;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: two instances (BPC=1 and BPC=4) against an arithmetic model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iv[2], ir[2], ov[2], ordy[2], ci[2], sb[2], co[2], of[2];
   logic [7:0] av[2], bv[2], sm[2];

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .BPC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(av[0]), .b(bv[0]), .cin(ci[0]),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sb[0]),
`endif
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .overflow(of[0])
   );

   serial_adder #(.WIDTH(8), .BPC(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(av[1]), .b(bv[1]), .cin(ci[1]),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sb[1]),
`endif
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .overflow(of[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on instance s, checked against plain arithmetic.
   task automatic run_op(input int s, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic tsub,
                         input int unsigned vgap, input int unsigned rgap);
      int unsigned n, lat;
      logic [7:0]  be;
      logic        ce, eovf;
      logic [8:0]  full;
      int          sres;
      n    = (s == 0) ? 8 : 2;
      be   = tsub ? ~tb : tb;
      ce   = tsub ? 1'b1 : tc;
      full = {1'b0, ta} + {1'b0, be} + {8'd0, ce};
      sres = int'($signed(ta)) + int'($signed(be)) + (ce ? 1 : 0);
      eovf = (sres > 127) || (sres < -128);

      iv[s] = 1'b0;
      repeat (vgap) begin
         av[s] = 8'($urandom);
         bv[s] = 8'($urandom);
         tick();
      end
      chk("idle_ready", 32'(ir[s]), 32'd1);
      chk("idle_valid", 32'(ov[s]), 32'd0);

      iv[s] = 1'b1; av[s] = ta; bv[s] = tb; ci[s] = tc; sb[s] = tsub;
      tick();
      lat = 0;
      while (!ov[s] && lat < 40) begin
         chk("busy_ready", 32'(ir[s]), 32'd0);
         iv[s]   = 1'($urandom);
         av[s]   = 8'($urandom);
         bv[s]   = 8'($urandom);
         ci[s]   = 1'($urandom);
         sb[s]   = 1'($urandom);
         ordy[s] = 1'($urandom);
         tick();
         lat++;
      end
      iv[s]   = 1'b0;
      ordy[s] = 1'b0;
      chk("latency", lat, n);
      chk("sum", 32'(sm[s]), 32'(full[7:0]));
      chk("cout", 32'(co[s]), 32'(full[8]));
      chk("overflow", 32'(of[s]), 32'(eovf));

      repeat (rgap) begin
         tick();
         chk("hold_valid", 32'(ov[s]), 32'd1);
         chk("hold_ready", 32'(ir[s]), 32'd0);
         chk("hold_sum", 32'(sm[s]), 32'(full[7:0]));
         chk("hold_cout", 32'(co[s]), 32'(full[8]));
         chk("hold_ovf", 32'(of[s]), 32'(eovf));
      end

      ordy[s] = 1'b1;
      tick();
      ordy[s] = 1'b0;
      chk("handoff_valid", 32'(ov[s]), 32'd0);
      chk("handoff_ready", 32'(ir[s]), 32'd1);
   endtask

   initial begin
      #5ms;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic       rs;
      logic [7:0] ra, rb;
      logic       rc, rsub;
      int         rsel;

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; ci[k] = 1'b0; sb[k] = 1'b0;
         av[k] = '0;   bv[k] = '0;
      end
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", 32'(ir[k]), 32'd1);
         chk("rst_valid", 32'(ov[k]), 32'd0);
         chk("rst_sum", 32'(sm[k]), 32'd0);
         chk("rst_cout", 32'(co[k]), 32'd0);
         chk("rst_ovf", 32'(of[k]), 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // Directed corner cases.
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 2);
      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1, 0);
      run_op(1, 8'hA5, 8'h5A, 1'b1, 1'b0, 0, 3);
      run_op(0, 8'h80, 8'h80, 1'b0, 1'b0, 0, 0);
      run_op(1, 8'h7F, 8'h00, 1'b1, 1'b0, 2, 1);
`ifdef SERIAL_ADDER_SUB_EN
      run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, 1);
      run_op(0, 8'h80, 8'h01, 1'b1, 1'b1, 0, 1);
      run_op(1, 8'h05, 8'h07, 1'b1, 1'b1, 0, 0);
`endif

      // Reset on the third CALC cycle aborts the operation.
      iv[0] = 1'b1; av[0] = 8'h33; bv[0] = 8'h44; ci[0] = 1'b0; sb[0] = 1'b0;
      tick();
      iv[0] = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_valid", 32'(ov[0]), 32'd0);
      chk("abort_ready", 32'(ir[0]), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_quiet", 32'(ov[0]), 32'd0);
      end
      run_op(0, 8'h12, 8'hF0, 1'b1, 1'b0, 0, 1);

      // Randomized operations with random handshake gaps.
      for (int i = 0; i < 1000; i++) begin
         rs   = 1'($urandom);
         rsel = rs ? 1 : 0;
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rsub = 1'($urandom);
`else
         rsub = 1'b0;
`endif
         run_op(rsel, ra, rb, rc, rsub, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
